// File: rtl/tlu_dut_rx.sv
// TLU trigger/ID receiver: sync, handshake FSM, serial ID clock-in.
// Optional glitch filter via TLU_DUT_RX_DEBOUNCE_EN.
module tlu_dut_rx #(
    parameter int INV_IO = 0
) (
    input  logic        SYS_CLK,
    input  logic        SYS_RST,
    input  logic        ENABLE,
    input  logic [4:0]  CONF_N_BITS,
    input  logic [7:0]  CONF_CLK_DIV,
    input  logic        TLU_TRIGGER,
    output logic        TLU_BUSY,
    output logic        TLU_CLOCK,
    output logic [30:0] ID_DATA,
    output logic        ID_VALID,
    input  logic        ID_ACK,
    output logic [31:0] TRIG_CNT,
    output logic [15:0] LOST_CNT,
    output logic [2:0]  STATE_OUT
);

    localparam logic [2:0] S_IDLE  = 3'b001;
    localparam logic [2:0] S_SHIFT = 3'b010;
    localparam logic [2:0] S_REL   = 3'b100;
    localparam logic       INV     = (INV_IO != 0);

    logic [2:0]  state, state_nxt;
    logic        trg_in, trg_m, trg_s;
    logic [1:0]  fill;
    logic        armed;
    logic        detect;
    logic        busy_d, busy_q, clk_q;
    logic [4:0]  n_lat, bit_cnt;
    logic [7:0]  d_lat, d_cfg, div_cnt;
    logic        in_setup;
    logic        shift_done;
    logic [30:0] shreg;

    assign trg_in = TLU_TRIGGER ^ INV;
    assign d_cfg  = (CONF_CLK_DIV == 8'd0) ? 8'd1 : CONF_CLK_DIV;

`ifdef TLU_DUT_RX_DEBOUNCE_EN
    logic [1:0] hi_cnt;

    always_ff @(posedge SYS_CLK) begin
        if (SYS_RST)
            hi_cnt <= 2'd0;
        else if (!trg_s)
            hi_cnt <= 2'd0;
        else if (hi_cnt != 2'd3)
            hi_cnt <= hi_cnt + 2'd1;
    end

    assign detect = state[0] & armed & ENABLE & trg_s & (hi_cnt == 2'd2);
`else
    logic trg_prev;

    always_ff @(posedge SYS_CLK) begin
        if (SYS_RST)
            trg_prev <= 1'b0;
        else
            trg_prev <= trg_s;
    end

    assign detect = state[0] & armed & ENABLE & trg_s & ~trg_prev;
`endif

    // fill marks trg_s as a real sample rather than its reset value
    always_ff @(posedge SYS_CLK) begin
        if (SYS_RST) begin
            trg_m <= 1'b0;
            trg_s <= 1'b0;
            fill  <= 2'b00;
            armed <= 1'b0;
        end else begin
            trg_m <= trg_in;
            trg_s <= trg_m;
            fill  <= {fill[0], 1'b1};
            if (detect)
                armed <= 1'b0;
            else if ((state[0] | state[2]) & ~trg_s & fill[1])
                armed <= 1'b1;
        end
    end

    assign shift_done = state[1] & (div_cnt == 8'd0) &
        ((in_setup & (n_lat == 5'd0)) |
         (~in_setup & ~clk_q & (bit_cnt == n_lat - 5'd1)));

    always_ff @(posedge SYS_CLK) begin
        if (SYS_RST)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (1'b1)
            state[0]: if (detect)     state_nxt = S_SHIFT;
            state[1]: if (shift_done) state_nxt = S_REL;
            state[2]: if (!trg_s)     state_nxt = S_IDLE;
            default:                  state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        busy_d = (state != S_IDLE);
    end

    always_ff @(posedge SYS_CLK) begin
        if (SYS_RST) begin
            busy_q   <= 1'b0;
            clk_q    <= 1'b0;
            n_lat    <= 5'd0;
            d_lat    <= 8'd1;
            div_cnt  <= 8'd0;
            bit_cnt  <= 5'd0;
            in_setup <= 1'b0;
            shreg    <= 31'd0;
            TRIG_CNT <= 32'd0;
        end else begin
            busy_q <= busy_d;
            if (detect) begin
                n_lat    <= CONF_N_BITS;
                d_lat    <= d_cfg;
                div_cnt  <= d_cfg - 8'd1;
                bit_cnt  <= 5'd0;
                in_setup <= 1'b1;
                clk_q    <= 1'b0;
                shreg    <= 31'd0;
                TRIG_CNT <= TRIG_CNT + 32'd1;
            end else if (state[1]) begin
                if (div_cnt != 8'd0) begin
                    div_cnt <= div_cnt - 8'd1;
                end else begin
                    div_cnt <= d_lat - 8'd1;
                    if (in_setup) begin
                        in_setup <= 1'b0;
                        clk_q    <= (n_lat != 5'd0);
                    end else if (clk_q) begin
                        clk_q          <= 1'b0;
                        shreg[bit_cnt] <= trg_s;
                    end else begin
                        bit_cnt <= bit_cnt + 5'd1;
                        clk_q   <= ~shift_done;
                    end
                end
            end
        end
    end

    // a fresh ID wins over a same-cycle ack of the old one
    always_ff @(posedge SYS_CLK) begin
        if (SYS_RST) begin
            ID_DATA  <= 31'd0;
            ID_VALID <= 1'b0;
            LOST_CNT <= 16'd0;
        end else if (shift_done & (~ID_VALID | ID_ACK)) begin
            ID_DATA  <= shreg;
            ID_VALID <= 1'b1;
        end else begin
            if (shift_done && LOST_CNT != 16'hFFFF)
                LOST_CNT <= LOST_CNT + 16'd1;
            if (ID_ACK)
                ID_VALID <= 1'b0;
        end
    end

    assign TLU_BUSY  = busy_q ^ INV;
    assign TLU_CLOCK = clk_q ^ INV;
    assign STATE_OUT = state;

endmodule

// File: tb/tb_tlu_dut_rx.sv
// Directed bench for tlu_dut_rx with a behavioural TLU master
// and an expected-ID queue.
module tb_tlu_dut_rx;

    logic        SYS_CLK = 1'b0;
    logic        SYS_RST = 1'b1;
    logic        ENABLE = 1'b1;
    logic [4:0]  CONF_N_BITS = 5'd0;
    logic [7:0]  CONF_CLK_DIV = 8'd1;
    logic        tlu_trigger;
    logic        TLU_BUSY, TLU_CLOCK;
    logic [30:0] ID_DATA;
    logic        ID_VALID;
    logic        ID_ACK = 1'b0;
    logic [31:0] TRIG_CNT;
    logic [15:0] LOST_CNT;
    logic [2:0]  STATE_OUT;

    logic        trig_req = 1'b0;
    logic        m_act = 1'b0, m_bit = 1'b0, m_pclk = 1'b0;
    logic [30:0] m_id = 31'd0;
    int          m_idx = 0;

    int passes = 0;
    int total = 0;
    logic [30:0] exp_q[$];

`ifdef TLU_DUT_RX_DEBOUNCE_EN
    localparam int LAT = 6;
`else
    localparam int LAT = 4;
`endif

    always #5 SYS_CLK = ~SYS_CLK;

    assign tlu_trigger = m_act ? m_bit : trig_req;

    tlu_dut_rx dut (
        .SYS_CLK(SYS_CLK), .SYS_RST(SYS_RST), .ENABLE(ENABLE),
        .CONF_N_BITS(CONF_N_BITS), .CONF_CLK_DIV(CONF_CLK_DIV),
        .TLU_TRIGGER(tlu_trigger), .TLU_BUSY(TLU_BUSY),
        .TLU_CLOCK(TLU_CLOCK), .ID_DATA(ID_DATA), .ID_VALID(ID_VALID),
        .ID_ACK(ID_ACK), .TRIG_CNT(TRIG_CNT), .LOST_CNT(LOST_CNT),
        .STATE_OUT(STATE_OUT)
    );

    // master: bit 0 when busy rises, next bit on each TLU_CLOCK fall
    always @(negedge SYS_CLK) begin
        if (!TLU_BUSY) begin
            m_act = 1'b0;
            m_idx = 0;
        end else if (!m_act) begin
            m_act = 1'b1;
            m_idx = 0;
            m_bit = m_id[0];
        end else if (m_pclk && !TLU_CLOCK) begin
            m_idx++;
            m_bit = (m_idx < 31) ? m_id[m_idx] : 1'b0;
        end
        m_pclk = TLU_CLOCK;
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic ack_pulse();
        @(negedge SYS_CLK);
        ID_ACK = 1'b1;
        @(negedge SYS_CLK);
        ID_ACK = 1'b0;
    endtask

    task automatic run_txn(input logic [30:0] id, input int n, input int d,
                           input bit ack_end, input bit en_drop,
                           input int rst_at, input bit keep);
        int lat, rises, hicyc, busyc, ackcd;
        logic pclk;
        lat = 0; rises = 0; hicyc = 0; busyc = 1; ackcd = 0; pclk = 1'b0;
        m_id = id;
        CONF_N_BITS = n[4:0];
        CONF_CLK_DIV = d[7:0];
        @(negedge SYS_CLK);
        trig_req = 1'b1;
        while (!TLU_BUSY && lat < 50) begin
            @(negedge SYS_CLK);
            lat++;
        end
        chk("latency", lat, LAT);
        if (!keep) trig_req = 1'b0;
        CONF_N_BITS = 5'd7;
        CONF_CLK_DIV = 8'd9;
        while (TLU_BUSY && busyc < 3000) begin
            @(negedge SYS_CLK);
            ID_ACK = 1'b0;
            if (ackcd > 0) begin
                ackcd--;
                if (ackcd == 0) ID_ACK = 1'b1;
            end
            if (TLU_CLOCK) hicyc++;
            if (TLU_CLOCK && !pclk) begin
                rises++;
                if (en_drop && rises == 2) ENABLE = 1'b0;
                if (rises == rst_at) begin
                    SYS_RST = 1'b1;
                    @(negedge SYS_CLK);
                    SYS_RST = 1'b0;
                    return;
                end
            end
            if (!TLU_CLOCK && pclk && rises == n && ack_end) begin
                ackcd = d - 1;
                if (ackcd == 0) ID_ACK = 1'b1;
            end
            pclk = TLU_CLOCK;
            if (TLU_BUSY) busyc++;
        end
        ID_ACK = 1'b0;
        chk("busy_timeout", (busyc < 3000), 1);
        chk("pulses", rises, n);
        chk("high_cycles", hicyc, n * d);
        chk("busy_len", (busyc >= d + 2 * n * d), 1);
    endtask

    initial begin : main
        int seen;
        int lat;
        repeat (3) @(negedge SYS_CLK);
        chk("rst_busy", TLU_BUSY, 0);
        chk("rst_clock", TLU_CLOCK, 0);
        chk("rst_data", ID_DATA, 0);
        chk("rst_valid", ID_VALID, 0);
        chk("rst_trig", TRIG_CNT, 0);
        chk("rst_lost", LOST_CNT, 0);
        chk("rst_state", STATE_OUT, 3'b001);
        SYS_RST = 1'b0;
        repeat (4) @(negedge SYS_CLK);

        exp_q.push_back(31'h1234);
        run_txn(31'h1234, 15, 2, 0, 0, 0, 0);
        chk("t1_valid", ID_VALID, 1);
        chk("t1_data", ID_DATA, exp_q.pop_front());
        chk("t1_trig", TRIG_CNT, 1);
        ack_pulse();
        chk("ack_clear", ID_VALID, 0);
        ack_pulse();
        chk("ack_idle", ID_VALID, 0);
        chk("ack_keep_data", ID_DATA, 31'h1234);

        repeat (3) @(negedge SYS_CLK);
        exp_q.push_back(31'h0);
        run_txn(31'h0, 0, 3, 0, 0, 0, 0);
        chk("n0_valid", ID_VALID, 1);
        chk("n0_data", ID_DATA, exp_q.pop_front());
        chk("n0_trig", TRIG_CNT, 2);
        ack_pulse();

        repeat (3) @(negedge SYS_CLK);
        exp_q.push_back(31'h5);
        run_txn(31'h5, 4, 2, 0, 0, 0, 0);
        chk("ov1_valid", ID_VALID, 1);
        chk("ov1_lost", LOST_CNT, 0);
        repeat (3) @(negedge SYS_CLK);
        run_txn(31'hA, 4, 2, 0, 0, 0, 0);
        chk("ov2_lost", LOST_CNT, 1);
        chk("ov2_data", ID_DATA, exp_q.pop_front());
        repeat (3) @(negedge SYS_CLK);
        exp_q.push_back(31'h3);
        run_txn(31'h3, 4, 2, 1, 0, 0, 0);
        chk("ov3_valid", ID_VALID, 1);
        chk("ov3_data", ID_DATA, exp_q.pop_front());
        chk("ov3_lost", LOST_CNT, 1);

        repeat (3) @(negedge SYS_CLK);
        run_txn(31'h15, 31, 2, 0, 0, 5, 1);
        chk("mrst_busy", TLU_BUSY, 0);
        chk("mrst_clock", TLU_CLOCK, 0);
        chk("mrst_data", ID_DATA, 0);
        chk("mrst_valid", ID_VALID, 0);
        chk("mrst_trig", TRIG_CNT, 0);
        chk("mrst_lost", LOST_CNT, 0);
        chk("mrst_state", STATE_OUT, 3'b001);
        seen = 0;
        repeat (20) begin
            @(negedge SYS_CLK);
            if (TLU_BUSY) seen++;
        end
        chk("no_retrigger", seen, 0);
        chk("no_retrig_cnt", TRIG_CNT, 0);
        trig_req = 1'b0;
        repeat (4) @(negedge SYS_CLK);

        ENABLE = 1'b0;
        repeat (2) @(negedge SYS_CLK);
        trig_req = 1'b1;
        seen = 0;
        repeat (12) begin
            @(negedge SYS_CLK);
            if (TLU_BUSY) seen++;
        end
        ENABLE = 1'b1;
        repeat (8) begin
            @(negedge SYS_CLK);
            if (TLU_BUSY) seen++;
        end
        chk("dis_busy", seen, 0);
        chk("dis_state", STATE_OUT, 3'b001);
        chk("dis_trig", TRIG_CNT, 0);
        trig_req = 1'b0;
        repeat (4) @(negedge SYS_CLK);

        exp_q.push_back(31'hA5);
        run_txn(31'hA5, 8, 2, 0, 1, 0, 0);
        ENABLE = 1'b1;
        chk("endrop_valid", ID_VALID, 1);
        chk("endrop_data", ID_DATA, exp_q.pop_front());
        chk("endrop_trig", TRIG_CNT, 1);
        ack_pulse();

`ifdef TLU_DUT_RX_DEBOUNCE_EN
        repeat (3) @(negedge SYS_CLK);
        trig_req = 1'b1;
        repeat (2) @(negedge SYS_CLK);
        trig_req = 1'b0;
        seen = 0;
        repeat (10) begin
            @(negedge SYS_CLK);
            if (TLU_BUSY) seen++;
        end
        chk("glitch_busy", seen, 0);
        chk("glitch_trig", TRIG_CNT, 1);
        CONF_N_BITS = 5'd0;
        CONF_CLK_DIV = 8'd2;
        m_id = 31'd0;
        @(negedge SYS_CLK);
        trig_req = 1'b1;
        lat = 0;
        repeat (3) begin
            @(negedge SYS_CLK);
            lat++;
        end
        trig_req = 1'b0;
        while (!TLU_BUSY && lat < 50) begin
            @(negedge SYS_CLK);
            lat++;
        end
        chk("pulse3_latency", lat, 6);
        seen = 0;
        while (TLU_BUSY && seen < 100) begin
            @(negedge SYS_CLK);
            seen++;
        end
        chk("pulse3_valid", ID_VALID, 1);
        chk("pulse3_trig", TRIG_CNT, 2);
`else
        lat = 0;
`endif

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
